// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit -- instruction-fetch sequencer for the 32-bit RISC-V core.
//
// Owns the program counter, keeps at most one instruction-memory request
// outstanding, and hands {instr, pc} pairs to decode through an output
// register backed by a one-entry skid buffer. Execute may redirect the PC at
// any time; in-flight responses that belong to the old stream are discarded.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   pc_o             current PC, feeds input a of the external PC adder
//   pc_plus4_i       PC adder result (pc_o + 4)
//   redirect_i       branch/jump taken, with target redirect_pc_i
//   stall_i          decode cannot accept an instruction this cycle
//   imem_req_o       fetch request valid, address on imem_addr_o
//   imem_gnt_i       request accepted
//   imem_rvalid_i    response valid, data on imem_rdata_i
//   instr_valid_o    instr_o / instr_pc_o valid to decode
//   misalign_o       one-cycle pulse: redirect target was not word aligned
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | just out of reset, nothing outstanding
// REQ   | presenting pc_q to imem (held off while the skid is full)
// WAIT  | request granted, waiting for its response
// FLUSH | request outstanding but redirected; its response is dropped

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_o,
    input  logic [31:0] pc_plus4_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        misalign_q, misalign_d;

    logic gnt_hs;
    logic rsp_hs;
    logic deliver;
    logic out_free;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        misalign_d   = 1'b0;

        gnt_hs   = (state_q == S_REQ) && !skid_valid_q && imem_gnt_i;
        rsp_hs   = (state_q == S_WAIT) && imem_rvalid_i;
        deliver  = rsp_hs && !redirect_i;
        out_free = !out_valid_q || !stall_i;

        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (gnt_hs) begin
                    pend_pc_d = pc_q;
                    pc_d      = pc_plus4_i;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT:  if (imem_rvalid_i) state_d = S_REQ;
            S_FLUSH: if (imem_rvalid_i) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase

        // The skid is only ever filled while the output register is stalled,
        // and requests stop while it is full, so it drains before new data.
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_instr_d  = skid_instr_q;
                out_pc_d     = skid_pc_q;
                skid_valid_d = deliver;
                if (deliver) begin
                    skid_instr_d = imem_rdata_i;
                    skid_pc_d    = pend_pc_q;
                end
            end else if (deliver) begin
                out_valid_d = 1'b1;
                out_instr_d = imem_rdata_i;
                out_pc_d    = pend_pc_q;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (deliver) begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_rdata_i;
            skid_pc_d    = pend_pc_q;
        end

        // Redirect wins over everything. A response still owed to the old
        // stream (granted now, or waiting / already flushing without rvalid)
        // must be swallowed in FLUSH before fetching again.
        if (redirect_i) begin
            pc_d         = {redirect_pc_i[31:2], 2'b00};
            misalign_d   = |redirect_pc_i[1:0];
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            if (gnt_hs ||
                ((state_q == S_WAIT || state_q == S_FLUSH) && !imem_rvalid_i))
                state_d = S_FLUSH;
            else
                state_d = S_REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            pend_pc_q    <= 32'h0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= 32'h0;
            out_pc_q     <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            misalign_q   <= misalign_d;
        end
    end

    assign pc_o          = pc_q;
    assign imem_req_o    = (state_q == S_REQ) && !skid_valid_q;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = out_valid_q;
    assign instr_o       = out_instr_q;
    assign instr_pc_o    = out_pc_q;
    assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam logic [31:0] KEY = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        stall_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        misalign_o;

    int n_cmp = 0;
    int n_err = 0;

    int gnt_budget = 0;
    int rsp_lat = 1;
    int rsp_cnt = 0;
    logic [31:0] rsp_addr = 32'h0;

    logic [63:0] exp_q[$];
    logic [31:0] addr_q[$];

    always #5 clk = ~clk;

    assign pc_plus4   = pc_o + 32'd4;
    assign imem_gnt_i = imem_req_o && (gnt_budget > 0);

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pc_o(pc_o),
        .pc_plus4_i(pc_plus4),
        .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .stall_i(stall_i),
        .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o),
        .instr_o(instr_o),
        .instr_pc_o(instr_pc_o),
        .misalign_o(misalign_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Memory model: handshake seen mid-cycle, response rsp_lat cycles later.
    initial begin
        logic hs;
        logic [31:0] hs_addr;
        forever begin
            @(negedge clk);
            hs      = imem_req_o && imem_gnt_i && rst_n;
            hs_addr = imem_addr_o;
            if (hs) begin
                n_cmp++;
                if (addr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_req: addr 0x%08h, none expected", hs_addr);
                end else begin
                    logic [31:0] ea;
                    ea = addr_q.pop_front();
                    if (hs_addr !== ea) begin
                        n_err++;
                        $display("FAIL fetch_addr: got 0x%08h want 0x%08h", hs_addr, ea);
                    end
                end
            end
            @(posedge clk);
            #1;
            imem_rvalid_i = 1'b0;
            if (hs) begin
                gnt_budget--;
                rsp_addr = hs_addr;
                rsp_cnt  = rsp_lat;
            end
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = rsp_addr ^ KEY;
                end
            end
        end
    end

    // Delivery monitor: compares every valid output against the queue head,
    // pops it when decode consumes it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && instr_valid_o) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_instr: pc 0x%08h instr 0x%08h", instr_pc_o, instr_o);
                end else begin
                    logic [63:0] e;
                    e = exp_q[0];
                    if ({instr_o, instr_pc_o} !== e) begin
                        n_err++;
                        $display("FAIL deliver: got pc 0x%08h instr 0x%08h want pc 0x%08h instr 0x%08h",
                                 instr_pc_o, instr_o, e[31:0], e[63:32]);
                    end
                    if (!stall_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_fetch(input logic [31:0] a, input bit delivered);
        addr_q.push_back(a);
        if (delivered) exp_q.push_back({a ^ KEY, a});
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || addr_q.size() != 0) && k < 200) begin
            cyc(1);
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: %0d instrs %0d fetches left, want 0", name, exp_q.size(), addr_q.size());
            exp_q.delete();
            addr_q.delete();
        end
    endtask

    task automatic redirect(input logic [31:0] tgt);
        redirect_i    = 1'b1;
        redirect_pc_i = tgt;
        cyc(1);
        redirect_i    = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(2);
        check("rst_pc", pc_o, 32'h0);
        check("rst_req", {31'b0, imem_req_o}, 32'h0);
        check("rst_valid", {31'b0, instr_valid_o}, 32'h0);
        check("rst_misalign", {31'b0, misalign_o}, 32'h0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_instr_pc", instr_pc_o, 32'h0);

        // 1: sequential fetch 0x0, 0x4, 0x8
        rst_n = 1'b1;
        rsp_lat = 1;
        expect_fetch(32'h0, 1'b1);
        expect_fetch(32'h4, 1'b1);
        expect_fetch(32'h8, 1'b1);
        gnt_budget = 3;
        drain("seq");

        // 2: stall 6 cycles, two responses, second goes to skid
        stall_i = 1'b1;
        expect_fetch(32'hC, 1'b1);
        expect_fetch(32'h10, 1'b1);
        gnt_budget = 2;
        cyc(5);
        check("skid_req_off", {31'b0, imem_req_o}, 32'h0);
        check("stall_valid", {31'b0, instr_valid_o}, 32'h1);
        cyc(1);
        stall_i = 1'b0;
        drain("stall");

        // 3: redirect while WAIT, stale response dropped
        rsp_lat = 3;
        expect_fetch(32'h14, 1'b0);
        gnt_budget = 1;
        cyc(1);
        redirect(32'h100);
        rsp_lat = 1;
        expect_fetch(32'h100, 1'b1);
        gnt_budget = 1;
        drain("redir_wait");

        // 4: redirect in the same cycle as rvalid
        rsp_lat = 2;
        expect_fetch(32'h104, 1'b0);
        gnt_budget = 1;
        cyc(2);
        redirect(32'h180);
        check("redir_rv_valid", {31'b0, instr_valid_o}, 32'h0);
        check("redir_rv_pc", pc_o, 32'h180);
        rsp_lat = 1;
        expect_fetch(32'h180, 1'b1);
        gnt_budget = 1;
        drain("redir_rv");

        // 5: misaligned target
        redirect(32'h0000_0206);
        check("misalign_pulse", {31'b0, misalign_o}, 32'h1);
        check("misalign_pc", pc_o, 32'h204);
        cyc(1);
        check("misalign_clear", {31'b0, misalign_o}, 32'h0);
        expect_fetch(32'h204, 1'b1);
        gnt_budget = 1;
        drain("misalign");

        // 6: wrap-around
        redirect(32'hFFFF_FFFC);
        check("wrap_misalign", {31'b0, misalign_o}, 32'h0);
        expect_fetch(32'hFFFF_FFFC, 1'b1);
        expect_fetch(32'h0000_0000, 1'b1);
        gnt_budget = 2;
        drain("wrap");
        check("wrap_pc", pc_o, 32'h4);

        // 7: reset during WAIT, later rvalid ignored
        rsp_lat = 3;
        expect_fetch(32'h4, 1'b0);
        gnt_budget = 1;
        cyc(1);
        rst_n = 1'b0;
        #1;
        check("midrst_pc", pc_o, 32'h0);
        check("midrst_req", {31'b0, imem_req_o}, 32'h0);
        check("midrst_valid", {31'b0, instr_valid_o}, 32'h0);
        cyc(1);
        rst_n = 1'b1;
        cyc(3);
        check("postrst_valid", {31'b0, instr_valid_o}, 32'h0);
        check("postrst_pc", pc_o, 32'h0);
        check("postrst_req", {31'b0, imem_req_o}, 32'h1);
        drain("reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
